// File: rtl/hdmi_fetch_pkg.sv
// Shared types and line geometry for the HDMI line-fetch scheduler.
// The constants describe the default 1080p configuration; the functions derive the same values for other geometries.
package hdmi_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    NEXT,
    HOLD
  } fetch_state_t;

  localparam int H_ACTIVE_DEF    = 1920;
  localparam int V_ACTIVE_DEF    = 1080;
  localparam int BURST_BEATS_DEF = 16;

  localparam int LINE_WORDS      = H_ACTIVE_DEF * 2 / 4;
  localparam int BURSTS_PER_LINE = LINE_WORDS / BURST_BEATS_DEF;
  localparam int BURST_BYTES     = BURST_BEATS_DEF * 4;
  localparam int LINE_STRIDE     = LINE_WORDS * 4;

  // 16-bit pixels packed two per 32-bit word
  function automatic int line_words(input int h_active);
    return h_active * 2 / 4;
  endfunction

endpackage

// File: rtl/line_bank_tracker.sv
// Two-bank line-buffer occupancy tracker: fill/display bank pointers, underrun detect.
// Underrun statistics counter present only when LINE_FETCH_STATS_EN is defined.
module line_bank_tracker (
  input  logic        system_clk,
  input  logic        reset_n,
  input  logic        hdmi_de,
  input  logic        frame_clr,
  input  logic        line_done,
  output logic [1:0]  bank_full,
  output logic        wr_bank,
  output logic        rd_bank,
  output logic        underrun,
  output logic [15:0] underrun_count
);

  logic       de_p1;
  logic       de_rise;
  logic       de_fall;
  logic [1:0] full_nxt;

  assign de_rise = hdmi_de & ~de_p1;
  assign de_fall = ~hdmi_de & de_p1;

  // Fill-side set is applied after display-side clear so a same-bank collision keeps the bank full
  always_comb begin
    full_nxt = bank_full;
    if (de_fall)   full_nxt[rd_bank] = 1'b0;
    if (line_done) full_nxt[wr_bank] = 1'b1;
    if (frame_clr) full_nxt = 2'b00;
  end

  always_ff @(posedge system_clk or negedge reset_n) begin
    if (!reset_n) begin
      de_p1     <= 1'b0;
      bank_full <= 2'b00;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      de_p1     <= hdmi_de;
      bank_full <= full_nxt;
      underrun  <= de_rise & ~bank_full[rd_bank];
      if (frame_clr) begin
        wr_bank <= 1'b0;
        rd_bank <= 1'b0;
      end else begin
        if (line_done) wr_bank <= ~wr_bank;
        if (de_fall)   rd_bank <= ~rd_bank;
      end
    end
  end

`ifdef LINE_FETCH_STATS_EN
  always_ff @(posedge system_clk or negedge reset_n) begin
    if (!reset_n) begin
      underrun_count <= 16'h0000;
    end else if (underrun && (underrun_count != 16'hFFFF)) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end
`else
  assign underrun_count = 16'h0000;
`endif

endmodule

// File: rtl/hdmi_line_fetch_ctrl.sv
// Per-line AXI burst read scheduler feeding a two-bank HDMI line buffer.
// Optional underrun statistics: define LINE_FETCH_STATS_EN.
module hdmi_line_fetch_ctrl
  import hdmi_fetch_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int BURST_BEATS = BURST_BEATS_DEF,
  parameter int ADDR_W      = 32
) (
  input  logic              system_clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic              hdmi_vsync,
  input  logic              hdmi_de,
  output logic              txn_request,
  output logic [ADDR_W-1:0] txn_addr,
  output logic [7:0]        txn_len,
  input  logic              wea,
  input  logic              reads_done,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic              underrun,
  output logic              beat_err,
  output logic [15:0]       underrun_count
);

  localparam int L_WORDS  = line_words(H_ACTIVE);
  localparam int L_BURSTS = L_WORDS / BURST_BEATS;
  localparam int L_STRIDE = L_WORDS * 4;
  localparam int B_BYTES  = BURST_BEATS * 4;
  localparam int LINE_W   = $clog2(V_ACTIVE + 1);
  localparam int BURST_W  = $clog2(L_BURSTS + 1);
  localparam int BEAT_W   = $clog2(BURST_BEATS + 1) + 1;

  if ((L_WORDS % BURST_BEATS) != 0 || L_BURSTS == 0) begin : g_bad_geometry
    $error("line words not a whole number of bursts");
  end

  fetch_state_t        state, state_nxt;
  logic                vsync_p1, fs_p1, fs_pend;
  logic                apply_frame, line_done, adv_burst;
  logic [ADDR_W-1:0]   base_q, next_addr;
  logic [LINE_W-1:0]   line_cnt, line_n;
  logic [BURST_W-1:0]  burst_cnt, burst_n;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [1:0]          bank_full;

  assign txn_request = (state == REQ) || (state == WAIT);
  assign txn_len     = 8'(BURST_BEATS - 1);

  // A frame start seen mid-burst is parked in fs_pend and applied from NEXT
  always_comb begin
    state_nxt   = state;
    apply_frame = 1'b0;
    line_done   = 1'b0;
    adv_burst   = 1'b0;
    case (state)
      IDLE: if (fs_p1) begin
        apply_frame = 1'b1;
        state_nxt   = REQ;
      end
      REQ:  state_nxt = WAIT;
      WAIT: if (reads_done) state_nxt = NEXT;
      NEXT: begin
        if (fs_p1 || fs_pend) begin
          apply_frame = 1'b1;
          state_nxt   = REQ;
        end else if (burst_cnt < BURST_W'(L_BURSTS - 1)) begin
          adv_burst = 1'b1;
          state_nxt = REQ;
        end else begin
          line_done = 1'b1;
          state_nxt = (line_cnt == LINE_W'(V_ACTIVE - 1)) ? IDLE : HOLD;
        end
      end
      HOLD: begin
        if (fs_p1) begin
          apply_frame = 1'b1;
          state_nxt   = REQ;
        end else if (!bank_full[wr_bank]) begin
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    line_n  = line_cnt;
    burst_n = burst_cnt;
    if (apply_frame) begin
      line_n  = '0;
      burst_n = '0;
    end else if (adv_burst) begin
      burst_n = burst_cnt + 1'b1;
    end else if (line_done) begin
      burst_n = '0;
      line_n  = line_cnt + 1'b1;
    end
    next_addr = (apply_frame ? frame_base : base_q)
              + ADDR_W'(line_n) * ADDR_W'(L_STRIDE)
              + ADDR_W'(burst_n) * ADDR_W'(B_BYTES);
  end

  always_ff @(posedge system_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      vsync_p1  <= 1'b0;
      fs_p1     <= 1'b0;
      fs_pend   <= 1'b0;
      line_cnt  <= '0;
      burst_cnt <= '0;
      txn_addr  <= '0;
      beat_cnt  <= '0;
      beat_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      vsync_p1  <= hdmi_vsync;
      fs_p1     <= hdmi_vsync & ~vsync_p1;
      line_cnt  <= line_n;
      burst_cnt <= burst_n;
      if (apply_frame) fs_pend <= 1'b0;
      else if (fs_p1 && txn_request) fs_pend <= 1'b1;
      if (apply_frame || adv_burst || line_done) txn_addr <= next_addr;
      if (reads_done) begin
        beat_cnt <= '0;
        if ((beat_cnt + BEAT_W'(wea)) != BEAT_W'(BURST_BEATS)) beat_err <= 1'b1;
      end else if (wea && (beat_cnt != '1)) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge system_clk) begin
    if (apply_frame) base_q <= frame_base;
  end

  line_bank_tracker u_bank_tracker (
    .system_clk     (system_clk),
    .reset_n        (reset_n),
    .hdmi_de        (hdmi_de),
    .frame_clr      (apply_frame),
    .line_done      (line_done),
    .bank_full      (bank_full),
    .wr_bank        (wr_bank),
    .rd_bank        (rd_bank),
    .underrun       (underrun),
    .underrun_count (underrun_count)
  );

endmodule

// File: tb/tb_hdmi_line_fetch_ctrl.sv
// Bench for hdmi_line_fetch_ctrl: randomized AXI master and display timing against a line/bank reference model.
module tb_hdmi_line_fetch_ctrl;

  localparam int BPL        = (1920 * 2 / 4) / 16;
  localparam int BURST_B    = 16 * 4;
  localparam int LINE_BYTES = (1920 * 2 / 4) * 4;

  logic        system_clk = 1'b0;
  logic        reset_n;
  logic [31:0] frame_base;
  logic        hdmi_vsync, hdmi_de, wea, reads_done;
  logic        txn_request;
  logic [31:0] txn_addr;
  logic [7:0]  txn_len;
  logic        wr_bank, rd_bank, underrun, beat_err;
  logic [15:0] underrun_count;

  always #5 system_clk = ~system_clk;

  hdmi_line_fetch_ctrl dut (
    .system_clk     (system_clk),
    .reset_n        (reset_n),
    .frame_base     (frame_base),
    .hdmi_vsync     (hdmi_vsync),
    .hdmi_de        (hdmi_de),
    .txn_request    (txn_request),
    .txn_addr       (txn_addr),
    .txn_len        (txn_len),
    .wea            (wea),
    .reads_done     (reads_done),
    .wr_bank        (wr_bank),
    .rd_bank        (rd_bank),
    .underrun       (underrun),
    .beat_err       (beat_err),
    .underrun_count (underrun_count)
  );

  int checks   = 0;
  int failures = 0;

  // reference model: frame-relative burst index, bank pointers and occupancy
  logic [31:0] m_base;
  int          m_k;
  logic        m_wr, m_rd, m_beat_err;
  logic [1:0]  m_full;
  int          m_ur;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge system_clk);
    #1;
  endtask

  function automatic logic [31:0] exp_addr();
    return m_base + 32'((m_k / BPL) * LINE_BYTES) + 32'((m_k % BPL) * BURST_B);
  endfunction

  task automatic model_frame(input logic [31:0] base);
    m_base = base;
    m_k    = 0;
    m_wr   = 1'b0;
    m_rd   = 1'b0;
    m_full = 2'b00;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!txn_request && n < 300) begin
      step();
      n++;
    end
    check_eq(tag, txn_request, 1'b1);
  endtask

  task automatic serve_burst(input int beats, input bit fs_pending);
    logic line_end;
    wait_req("req_seen");
    check_eq("burst_addr", txn_addr, exp_addr());
    check_eq("txn_len", txn_len, 32'd15);
    repeat ($urandom_range(0, 3)) step();
    for (int b = 0; b < beats; b++) begin
      wea = 1'b1;
      step();
      wea = 1'b0;
      repeat ($urandom_range(0, 2)) step();
    end
    check_eq("addr_stable", txn_addr, exp_addr());
    reads_done = 1'b1;
    step();
    reads_done = 1'b0;
    if (beats != 16) m_beat_err = 1'b1;
    check_eq("req_drop", txn_request, 1'b0);
    check_eq("beat_err", beat_err, m_beat_err);
    step();
    if (fs_pending) begin
      model_frame(frame_base);
      line_end = 1'b0;
    end else begin
      m_k++;
      line_end = ((m_k % BPL) == 0);
      if (line_end) begin
        m_full[m_wr] = 1'b1;
        m_wr = ~m_wr;
      end
    end
    check_eq("wr_bank", wr_bank, m_wr);
    check_eq("req_after_done", txn_request, !line_end);
  endtask

  task automatic de_cycle(input int hold);
    logic exp_ur;
    exp_ur  = !m_full[m_rd];
    hdmi_de = 1'b1;
    step();
    check_eq("underrun", underrun, exp_ur);
    step();
    check_eq("underrun_width", underrun, 1'b0);
    if (exp_ur && m_ur < 65535) m_ur++;
`ifdef LINE_FETCH_STATS_EN
    check_eq("underrun_count", underrun_count, m_ur);
`else
    check_eq("underrun_count", underrun_count, 32'd0);
`endif
    repeat (hold) step();
    hdmi_de = 1'b0;
    step();
    m_full[m_rd] = 1'b0;
    m_rd = ~m_rd;
    check_eq("rd_bank", rd_bank, m_rd);
  endtask

  task automatic vsync_start(input logic [31:0] base);
    frame_base = base;
    hdmi_vsync = 1'b1;
    step();
    check_eq("fs_lat1", txn_request, 1'b0);
    hdmi_vsync = 1'b0;
    step();
    check_eq("fs_lat2", txn_request, 1'b1);
    check_eq("fs_addr", txn_addr, base);
    model_frame(base);
  endtask

  initial begin
    bit seen;
    reset_n = 1'b0; hdmi_vsync = 1'b0; hdmi_de = 1'b0; wea = 1'b0; reads_done = 1'b0;
    frame_base = 32'h1000_0000;
    model_frame(32'h0);
    m_beat_err = 1'b0;
    m_ur = 0;

    repeat (3) step();
    check_eq("rst_req", txn_request, 1'b0);
    check_eq("rst_addr", txn_addr, 32'h0);
    check_eq("rst_len", txn_len, 32'd15);
    check_eq("rst_wr", wr_bank, 1'b0);
    check_eq("rst_rd", rd_bank, 1'b0);
    check_eq("rst_ur", underrun, 1'b0);
    check_eq("rst_berr", beat_err, 1'b0);
    check_eq("rst_urc", underrun_count, 32'd0);

    reset_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin step(); if (txn_request) seen = 1'b1; end
    check_eq("idle_no_req", seen, 1'b0);

    // two lines prefetched into both banks, base changes mid-frame ignored
    vsync_start(32'h1000_0000);
    frame_base = $urandom;
    for (int i = 0; i < 2 * BPL; i++) serve_burst(16, 1'b0);
    seen = 1'b0;
    repeat (50) begin step(); if (txn_request) seen = 1'b1; end
    check_eq("hold_no_req", seen, 1'b0);

    // display bank 0 frees it, line 2 fetches into bank 0
    de_cycle($urandom_range(5, 20));
    for (int i = 0; i < BPL; i++) serve_burst(16, 1'b0);

    // master stalls on line 3 while display drains both banks
    de_cycle($urandom_range(5, 20));
    wait_req("stall_req");
    de_cycle($urandom_range(5, 20));
    de_cycle($urandom_range(5, 20));

    // short burst sets sticky beat_err
    serve_burst(15, 1'b0);

    // frame start during WAIT, new base applied after the in-flight burst
    wait_req("fs_wait_req");
    frame_base = 32'h2000_0000;
    hdmi_vsync = 1'b1;
    step();
    hdmi_vsync = 1'b0;
    step();
    step();
    serve_burst(16, 1'b1);
    check_eq("fs_rd_bank", rd_bank, 1'b0);
    for (int i = 0; i < 3; i++) serve_burst(16, 1'b0);

    // asynchronous reset in the middle of a burst
    wait_req("rst_wait_req");
    for (int b = 0; b < 5; b++) begin wea = 1'b1; step(); wea = 1'b0; end
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_rst_req", txn_request, 1'b0);
    check_eq("async_rst_addr", txn_addr, 32'h0);
    check_eq("async_rst_berr", beat_err, 1'b0);
    check_eq("async_rst_wr", wr_bank, 1'b0);
    check_eq("async_rst_urc", underrun_count, 32'd0);
    step();
    reset_n = 1'b1;
    m_beat_err = 1'b0;
    m_ur = 0;
    model_frame(32'h0);
    seen = 1'b0;
    repeat (20) begin step(); if (txn_request) seen = 1'b1; end
    check_eq("post_rst_idle", seen, 1'b0);
    vsync_start(32'h3000_0000);
    for (int i = 0; i < 2; i++) serve_burst(16, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
